// File: rtl/rom_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_reader_pkg
// Description : Shared types and constants for the bipolar PROM dump reader:
//               FSM state encoding, default operation pin codes and the
//               bus widths of the supported chip types.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_reader_pkg;

    // Reader FSM states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Operation pin codes (bit 0 = V1)
    localparam logic [3:0] C_OP_READ_DEFAULT = 4'b1100;
    localparam logic [3:0] C_OP_IDLE_DEFAULT = 4'b0011;

    // Chip geometries
    localparam int C_DATA_WIDTH_3604    = 8;
    localparam int C_ADDRESS_WIDTH_3604 = 9;
    localparam int C_DATA_WIDTH_3601    = 4;
    localparam int C_ADDRESS_WIDTH_3601 = 8;

endpackage
`default_nettype wire

// File: rtl/rom_scan_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_scan_reader_if
// Description : Chip socket pins, control pulses and the captured-word
//               valid/ready handshake of the PROM reader. The master modport
//               is the reader itself. The checksum signal exists only when
//               ROM_READER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_scan_reader_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     start;
    logic                     auto_mode;
    logic                     increment_address;
    logic                     decrement_address;
    logic [DATA_WIDTH-1:0]    data_line_in;
    logic [3:0]               operation;
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [DATA_WIDTH-1:0]    data_line;
    logic [ADDRESS_WIDTH-1:0] data_addr;
    logic                     data_valid;
    logic                     data_ready;
    logic                     busy;
    logic                     done;
`ifdef ROM_READER_CHECKSUM_EN
    logic [15:0]              checksum;

    modport master (
        input  start, auto_mode, increment_address, decrement_address,
        input  data_line_in, data_ready,
        output operation, address_line, data_line, data_addr,
        output data_valid, busy, done, checksum
    );
    modport slave (
        output start, auto_mode, increment_address, decrement_address,
        output data_line_in, data_ready,
        input  operation, address_line, data_line, data_addr,
        input  data_valid, busy, done, checksum
    );
`else
    modport master (
        input  start, auto_mode, increment_address, decrement_address,
        input  data_line_in, data_ready,
        output operation, address_line, data_line, data_addr,
        output data_valid, busy, done
    );
    modport slave (
        output start, auto_mode, increment_address, decrement_address,
        output data_line_in, data_ready,
        input  operation, address_line, data_line, data_addr,
        input  data_valid, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rom_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : rom_settle_timer
// Description : Loadable down-counter that stops at zero; o_expired is high
//               while the count is zero. Loading N gives N+1 cycles of count
//               before (and including) the expired cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_settle_timer #(
    parameter int WIDTH = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_value,
    input  wire logic             i_en,
    output logic                  o_expired
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise count down while enabled until zero
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_value;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rom_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_scan_reader
// Description : PROM dump controller. Drives chip address and operation
//               pins, waits a settle time, captures the data word and offers
//               it on a valid/ready handshake. Manual single-step browsing
//               or automatic full-range scanning.
//               Optional feature macro: ROM_READER_CHECKSUM_EN adds a 16-bit
//               running sum of words transferred during an auto scan.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_scan_reader
    import rom_reader_pkg::*;
#(
    parameter int         DATA_WIDTH    = C_DATA_WIDTH_3604,
    parameter int         ADDRESS_WIDTH = C_ADDRESS_WIDTH_3604,
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] OP_READ       = C_OP_READ_DEFAULT,
    parameter logic [3:0] OP_IDLE       = C_OP_IDLE_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    rom_scan_reader_if.master  bus
);
    // Timer loads SETTLE_CYCLES-1 so the SETTLE state lasts SETTLE_CYCLES cycles
    localparam int C_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0]       C_SETTLE_LOAD = C_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] C_ADDR_LAST   = '1;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] daddr_q, daddr_d;
    logic                     auto_q, auto_d;
    logic                     w_timer_load;
    logic                     w_settle_done;

    rom_settle_timer #(
        .WIDTH (C_CNT_W)
    ) u_settle_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_timer_load),
        .i_load_value (C_SETTLE_LOAD),
        .i_en         (state_q == ST_SETTLE),
        .o_expired    (w_settle_done)
    );

    // Next-state, address, capture and mode decisions
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        daddr_d      = daddr_q;
        auto_d       = auto_q;
        w_timer_load = 1'b0;
        unique case (state_q)
            // DONE accepts the same triggers as IDLE; leaving it clears done
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    auto_d  = bus.auto_mode;
                    state_d = ST_SETUP;
                    if (bus.auto_mode) begin
                        addr_d = '0;
                    end
                end else if (bus.increment_address && !bus.decrement_address) begin
                    auto_d  = 1'b0;
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_SETUP;
                end else if (bus.decrement_address && !bus.increment_address) begin
                    auto_d  = 1'b0;
                    addr_d  = addr_q - 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_timer_load = 1'b1;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                data_d  = bus.data_line_in;
                daddr_d = addr_q;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.data_ready) begin
                    if (!auto_q) begin
                        state_d = ST_IDLE;
                    end else if (addr_q == C_ADDR_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_SETUP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            daddr_q <= '0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            daddr_q <= daddr_d;
            auto_q  <= auto_d;
        end
    end

    assign bus.operation    = ((state_q == ST_SETUP) || (state_q == ST_SETTLE) ||
                               (state_q == ST_CAPTURE)) ? OP_READ : OP_IDLE;
    assign bus.address_line = addr_q;
    assign bus.data_line    = data_q;
    assign bus.data_addr    = daddr_q;
    assign bus.data_valid   = (state_q == ST_PRESENT);
    assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done         = (state_q == ST_DONE);

`ifdef ROM_READER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        w_auto_start;
    logic        w_auto_xfer;

    assign w_auto_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                          bus.start && bus.auto_mode;
    assign w_auto_xfer  = (state_q == ST_PRESENT) && bus.data_ready && auto_q;

    // Running sum: cleared by an auto start, accumulates auto-mode transfers only
    always_comb begin
        csum_d = csum_q;
        if (w_auto_start) begin
            csum_d = '0;
        end else if (w_auto_xfer) begin
            csum_d = csum_q + 16'(data_q);
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign bus.checksum = csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_scan_reader
// Description : Self-checking bench for rom_scan_reader. A transaction-level
//               model (current address, done flag, running sum) predicts
//               every captured word from the chip contents addr ^ 8'hA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_scan_reader;
    localparam int         DW  = 8;
    localparam int         AW  = 3;
    localparam int         SC  = 2;
    localparam logic [3:0] OPR = 4'b1100;
    localparam logic [3:0] OPI = 4'b0011;
    localparam int         LAT = SC + 3;
    localparam int         NADDR = 1 << AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rom_scan_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();

    rom_scan_reader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SETTLE_CYCLES (SC),
        .OP_READ       (OPR),
        .OP_IDLE       (OPI)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // PROM contents
    assign bus.data_line_in = {{(DW-AW){1'b0}}, bus.address_line} ^ 8'hA5;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int addr_m = 0;
    int done_m = 0;
    int csum_m = 0;

    function automatic int rom_m(input int a);
        return (a ^ 'hA5) & 'hFF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_sum();
`ifdef ROM_READER_CHECKSUM_EN
        check_eq("checksum", {16'h0, bus.checksum}, csum_m);
`endif
    endtask

    // kind: 0 auto start, 1 manual start, 2 inc, 3 dec, 4 inc+dec together
    task automatic do_trigger(input int kind);
        @(negedge clk);
        bus.start             = (kind <= 1);
        bus.auto_mode         = (kind == 0);
        bus.increment_address = (kind == 2) || (kind == 4);
        bus.decrement_address = (kind == 3) || (kind == 4);
        @(negedge clk);
        bus.start             = 1'b0;
        bus.auto_mode         = 1'b0;
        bus.increment_address = 1'b0;
        bus.decrement_address = 1'b0;
    endtask

    // Called one cycle after the trigger edge; waits (bounded) for data_valid
    task automatic wait_word(input int exp_addr, input bit ready_early, input bit poke);
        int  cyc   = 1;
        int  reads = 0;
        bit  seen  = 1'b0;
        if (ready_early) bus.data_ready = 1'b1;
        while (cyc <= 20) begin
            if (bus.data_valid) begin
                seen = 1'b1;
                break;
            end
            if (bus.operation == OPR) reads++;
            if (poke && cyc == 2) begin
                case ($urandom_range(0, 2))
                    0: bus.start = 1'b1;
                    1: bus.increment_address = 1'b1;
                    default: bus.decrement_address = 1'b1;
                endcase
                bus.auto_mode = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
            bus.start             = 1'b0;
            bus.auto_mode         = 1'b0;
            bus.increment_address = 1'b0;
            bus.decrement_address = 1'b0;
        end
        check_eq("valid_latency", seen ? cyc : 99, LAT);
        check_eq("read_cycles", reads, LAT - 1);
        check_eq("addr_during_read", bus.address_line, exp_addr);
    endtask

    // Called in the first valid cycle; optionally stalls, then transfers
    task automatic accept(input int exp_addr, input int stall, input bit keep_ready);
        check_eq("data_line", bus.data_line, rom_m(exp_addr));
        check_eq("data_addr", bus.data_addr, exp_addr);
        check_eq("op_present", bus.operation, OPI);
        check_eq("busy_present", bus.busy, 1);
        if (stall > 0) bus.data_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_valid", bus.data_valid, 1);
            check_eq("stall_data", bus.data_line, rom_m(exp_addr));
            check_eq("stall_addr", bus.address_line, exp_addr);
            check_eq("stall_op", bus.operation, OPI);
        end
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = keep_ready;
        check_eq("valid_drop", bus.data_valid, 0);
    endtask

    task automatic run_auto(input int stall_addr, input int stall_len,
                            input bit ready_high, input bit poke);
        addr_m = 0;
        csum_m = 0;
        done_m = 0;
        do_trigger(0);
        for (int a = 0; a < NADDR; a++) begin
            wait_word(a, ready_high, poke && (a == 3));
            accept(a, (a == stall_addr) ? stall_len : 0, ready_high);
            csum_m = (csum_m + rom_m(a)) % 65536;
            if (a < NADDR - 1) check_eq("auto_busy", bus.busy, 1);
        end
        bus.data_ready = 1'b0;
        addr_m = NADDR - 1;
        done_m = 1;
        check_eq("auto_done", bus.done, 1);
        check_eq("auto_idle_busy", bus.busy, 0);
        check_eq("auto_last_addr", bus.address_line, addr_m);
        check_eq("auto_op_idle", bus.operation, OPI);
        check_sum();
    endtask

    task automatic run_manual(input int kind, input bit poke);
        bit early;
        int stall;
        if (kind == 2) addr_m = (addr_m + 1) % NADDR;
        if (kind == 3) addr_m = (addr_m + NADDR - 1) % NADDR;
        early = 1'($urandom_range(0, 1));
        stall = early ? 0 : $urandom_range(0, 3);
        do_trigger(kind);
        wait_word(addr_m, early, poke);
        accept(addr_m, stall, 1'b0);
        done_m = 0;
        check_eq("man_busy", bus.busy, 0);
        check_eq("man_done", bus.done, done_m);
        check_eq("man_addr", bus.address_line, addr_m);
        check_sum();
    endtask

    task automatic run_both();
        do_trigger(4);
        for (int i = 0; i < 3; i++) begin
            check_eq("both_busy", bus.busy, 0);
            check_eq("both_valid", bus.data_valid, 0);
            @(negedge clk);
        end
        check_eq("both_addr", bus.address_line, addr_m);
        check_eq("both_done", bus.done, done_m);
    endtask

    task automatic run_reset_mid();
        do_trigger(0);
        @(negedge clk);   // now in the settle window
        reset_n = 1'b0;
        #1;
        check_eq("rst_op", bus.operation, OPI);
        check_eq("rst_addr", bus.address_line, 0);
        check_eq("rst_valid", bus.data_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        addr_m = 0;
        done_m = 0;
        csum_m = 0;
        check_sum();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.start             = 1'b0;
        bus.auto_mode         = 1'b0;
        bus.increment_address = 1'b0;
        bus.decrement_address = 1'b0;
        bus.data_ready        = 1'b0;
        reset_n               = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_op", bus.operation, OPI);
        check_eq("reset_addr", bus.address_line, 0);
        check_eq("reset_data", bus.data_line, 0);
        check_eq("reset_daddr", bus.data_addr, 0);
        check_eq("reset_valid", bus.data_valid, 0);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_done", bus.done, 0);
        check_sum();
        reset_n = 1'b1;
        @(negedge clk);

        run_auto(-1, 0, 1'b1, 1'b0);   // ready tied high
        run_auto(2, 5, 1'b0, 1'b0);    // stall at address 2
        run_reset_mid();
        run_manual(3, 1'b0);           // 0 -> 7
        run_manual(2, 1'b0);           // 7 -> 0
        run_both();
        run_manual(2, 1'b1);           // step pulse dropped during settle
        run_manual(1, 1'b0);
        run_auto(-1, 0, 1'b1, 1'b1);
        run_manual(3, 1'b0);           // step out of DONE

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0: run_auto($urandom_range(0, NADDR - 1), $urandom_range(0, 4),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: run_manual(1, 1'($urandom_range(0, 1)));
                2: run_manual(2, 1'($urandom_range(0, 1)));
                3: run_manual(3, 1'($urandom_range(0, 1)));
                4: run_both();
                default: run_reset_mid();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rom_scan_reader.md
# rom_scan_reader

Parametrised PROM dump controller for 556PT5 (3604), 556PT4 (3601) and similar bipolar PROMs. It sequences the chip address and operation pins, waits a programmable settle time, and captures the data word. The word is presented on a valid/ready handshake. Sits between the chip socket pins and the downstream display/UART dump logic, and supports single-step manual browsing and automatic full-range scanning.

## Interface
Parameters:
- DATA_WIDTH, 8: data bus width (4 for 3601).
- ADDRESS_WIDTH, 9: address bus width (8 for 3601).
- SETTLE_CYCLES, 4: clock cycles between address/operation change and capture, minimum 1.
- OP_READ, 4'b1100: operation pin code while reading.
- OP_IDLE, 4'b0011: operation pin code otherwise.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a read (manual) or a scan (auto).
- auto_mode  in  1  1 = scan whole range, 0 = manual; sampled only in IDLE.
- increment_address  in  1  one-cycle synchronous pulse, manual step +1.
- decrement_address  in  1  one-cycle synchronous pulse, manual step -1.
- data_line_in  in  DATA_WIDTH  data pins from chip.
- operation  out  4  chip operation pins V1..V4 (bit 0 = V1).
- address_line  out  ADDRESS_WIDTH  chip address pins.
- data_line  out  DATA_WIDTH  captured word.
- data_addr  out  ADDRESS_WIDTH  address the captured word came from.
- data_valid  out  1  captured word available.
- data_ready  in  1  consumer accepts word.
- busy  out  1  FSM not in IDLE/DONE.
- done  out  1  auto scan completed.
- checksum  out  16  present only with ROM_READER_CHECKSUM_EN.

## Operation
- Reset values: operation = OP_IDLE, address_line = 0, data_line = 0, data_addr = 0, data_valid = 0, busy = 0, done = 0, checksum = 0. Reset acts immediately in any state; no partial transfer completes.
- States: IDLE, SETUP, SETTLE, CAPTURE, PRESENT, DONE.
- IDLE triggers, accepted only in IDLE:
  - start with auto_mode=1: address := 0, done := 0, checksum := 0, then go to SETUP.
  - start with auto_mode=0: re-read the current address.
  - increment_address alone: address := address+1 mod 2^ADDRESS_WIDTH, then SETUP.
  - decrement_address alone: address := address-1 mod 2^ADDRESS_WIDTH, then SETUP.
  - increment and decrement in the same cycle: both ignored, stay IDLE. start has priority over both step pulses.
  - Triggers arriving outside IDLE are dropped.
- SETUP: 1 cycle, drives operation = OP_READ. SETTLE: SETTLE_CYCLES cycles. CAPTURE: 1 cycle; at its closing edge, data_line <= data_line_in and data_addr <= address.
- operation = OP_READ from SETUP through CAPTURE, and OP_IDLE in all other states.
- PRESENT: data_valid = 1. data_line and data_addr are held stable. Transfer occurs on a cycle with data_valid & data_ready.
- After the transfer:
  - manual mode: go to IDLE.
  - auto mode, address == 2^ADDRESS_WIDTH-1: go to DONE.
  - auto mode, otherwise: address+1, go to SETUP.
- DONE: done = 1 and address holds the last address. A start pulse behaves as in IDLE; step pulses also behave as in IDLE and clear done.
- The address counter is ADDRESS_WIDTH bits with natural wrap-around; there is no hard-coded 512.

## Timing
- Trigger sampled at edge k: SETUP in cycle k+1, CAPTURE in cycle k+2+SETTLE_CYCLES, data_valid high from edge k+3+SETTLE_CYCLES. Latency is SETTLE_CYCLES+3 cycles.
- data_ready is allowed to be high before data_valid; the transfer then happens in the first valid cycle.
- Auto scan throughput: one word per SETTLE_CYCLES+3 cycles with data_ready tied high. There is no return to IDLE between words.
- data_valid drops on the edge following the transfer.

## Configuration
- ROM_READER_CHECKSUM_EN defined:
  - checksum port exists.
  - 16-bit sum, mod 2^16, of zero-extended data_line over every auto-mode transfer.
  - Cleared on auto start; held in manual mode.
- Undefined: port and adder are absent; all other behaviour is identical.

## Structure
- Package rom_reader_pkg holds:
  - FSM state enum;
  - OP_READ/OP_IDLE default codes;
  - chip-type constants: data/address widths for 3604 (8/9) and 3601 (4/8).
- Sub-module rom_settle_timer: loadable down-counter with a terminal-count output, used by the SETTLE state.

## Test plan
Bench settings: ADDRESS_WIDTH=3, DATA_WIDTH=8, SETTLE_CYCLES=2; ROM model returns addr^8'hA5.
- Auto scan, ready high -> 8 transfers with data 0xA5,0xA4,0xA7,0xA6,0xA1,0xA0,0xA3,0xA2; data_addr 0..7; done=1 after addr 7; checksum = 0x051C (macro on).
- Auto scan with ready low for 5 cycles at address 2 -> data_valid, data_line=0xA7 and address_line=2 stable throughout; operation=OP_IDLE; transfer on release.
- Manual from address 0: decrement pulse -> address_line=7, data 0xA2 after 5 cycles; then increment pulse -> address 0, data 0xA5.
- Increment and decrement in the same cycle, plus a step pulse during SETTLE -> no address change, no extra transfer.
- reset_n low during SETTLE -> operation=OP_IDLE, address_line=0, data_valid=0 immediately; a later start scans again from 0.
- Manual start -> data_valid rises exactly 5 cycles after the start edge; operation=OP_READ for exactly 4 cycles.
